fixed_to_float_norm: RTL

//  Converts the signed fixed-point cosine word produced by the unrolled CORDIC pipeline into an

---
 rtl/fixed_to_float_norm_if.sv | 21 ++
 rtl/fixed_to_float_norm.sv | 104 ++++++++++
 2 files changed

// File: rtl/fixed_to_float_norm_if.sv
// rtl/fixed_to_float_norm_if.sv - start/done/clk_en handshake bundle for the fixed-to-float converter
interface fixed_to_float_norm_if #(
    parameter int WIDTH = 32
);
    logic             clk_en;
    logic             start;
    logic [WIDTH-1:0] fixed_in;
    logic [31:0]      result;
    logic             done;
    logic             busy;

    modport master (
        output clk_en, start, fixed_in,
        input  result, done, busy
    );

    modport slave (
        input  clk_en, start, fixed_in,
        output result, done, busy
    );
endinterface

// File: rtl/fixed_to_float_norm.sv
// rtl/fixed_to_float_norm.sv - signed fixed-point to IEEE-754 single, iterative normalise + RNE round
module fixed_to_float_norm #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    fixed_to_float_norm_if.slave  bus
);
    localparam int LZW      = $clog2(WIDTH);
    localparam int EXP_BASE = WIDTH - 1 - FRAC_BITS + 127;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mag;
    logic [LZW-1:0]   lz;
    logic             sign;
    logic [31:0]      result_q;
    logic             done_q;
    logic             busy_q;

    logic [WIDTH-1:0] abs_in;
    logic [22:0]      mant;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [23:0]      mant_sum;
    logic [9:0]       exp_val;
    logic [22:0]      mant_out;

    // Most-negative input negates to itself, which reads correctly as unsigned 2^(W-1).
    assign abs_in = bus.fixed_in[WIDTH-1] ? (~bus.fixed_in + 1'b1) : bus.fixed_in;

    assign mant  = mag[WIDTH-2 -: 23];
    assign guard = mag[WIDTH-25];

    generate
        if (WIDTH > 25) begin : g_sticky
            assign sticky = |mag[WIDTH-26:0];
        end else begin : g_no_sticky
            assign sticky = 1'b0;
        end
    endgenerate

    assign round_up = guard & (sticky | mant[0]);
    assign mant_sum = {1'b0, mant} + {23'd0, round_up};
    // A carry out of the mantissa bumps the exponent and leaves an all-zero fraction.
    assign exp_val  = 10'(EXP_BASE) - 10'(lz) + {9'd0, mant_sum[23]};
    assign mant_out = mant_sum[23] ? 23'd0 : mant_sum[22:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mag      <= '0;
            lz       <= '0;
            sign     <= 1'b0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (bus.clk_en) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.fixed_in == '0) begin
                            result_q <= 32'h0;
                            done_q   <= 1'b1;
                            state    <= DONE;
                        end else begin
                            sign  <= bus.fixed_in[WIDTH-1];
                            mag   <= abs_in;
                            lz    <= '0;
                            state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (mag[WIDTH-1]) begin
                        state <= ROUND;
                    end else begin
                        mag <= mag << 1;
                        lz  <= lz + 1'b1;
                    end
                end
                ROUND: begin
                    result_q <= {sign, exp_val[7:0], mant_out};
                    done_q   <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;
    assign bus.busy   = busy_q;
endmodule
